multicycle_control: RTL
=======================

# multicycle_control

Control unit for the multicycle 32-bit MIPS datapath. It sequences the PC, memory, instruction register, A/B operand registers, ALUOut and the register file one instruction at a time. Next state is computed from the current state, the opcode, and a memory-ready handshake. The datapath registers it drives latch on the falling edge, so every control output is stable over each full falling-edge sample.

## Interface
- Parameters: none.
- clk  in  1  system clock; state register updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- opcode  in  6  IR[31:26]; only used in DECODE.
- mem_ready  in  1  memory handshake; 1 means the current access completes this cycle.
- pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, ab_write  out  1  datapath controls.
- alu_src_b  out  2  ALU B source: 0 = B, 1 = const 4, 2 = sign-extended immediate, 3 = shifted immediate.
- alu_op  out  2  ALU op class: 0 = add, 1 = sub, 2 = funct, 3 = add-imm.
- pc_source  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Outputs are decoded combinationally from the state register. The only exception is the mem_ready-qualified enables listed below.
- States and codes:
  - FETCH 0: mem_read, alu_src_b=1, alu_op=0, pc_source=0. ir_write and pc_write are asserted only when mem_ready=1. Go to DECODE when mem_ready=1, otherwise stay in FETCH.
  - DECODE 1: ab_write=1, alu_src_b=3, alu_op=0. Branch on opcode:
    - 100011 (lw) or 101011 (sw): MEM_ADDR.
    - 000000 (R-type): EXECUTE.
    - 000100 (beq): BRANCH.
    - 000010 (j): JUMP.
    - 001000 (addi): ADDI_EXEC.
    - Any other opcode: pulse illegal_op and go to FETCH.
  - MEM_ADDR 2: alu_src_a=1, alu_src_b=2, alu_op=0. Go to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ 3: mem_read, ior_d. Go to MEM_WB when mem_ready=1, otherwise hold.
  - MEM_WB 4: reg_write, mem_to_reg, reg_dst=0. Go to FETCH.
  - MEM_WRITE 5: mem_write, ior_d. Go to FETCH when mem_ready=1, otherwise hold; mem_write stays asserted while holding.
  - EXECUTE 6: alu_src_a=1, alu_src_b=0, alu_op=2. Go to R_WB.
  - R_WB 7: reg_write, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH 8: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond, pc_source=1. Go to FETCH.
  - JUMP 9: pc_write, pc_source=2. Go to FETCH.
  - ADDI_EXEC 10: alu_src_a=1, alu_src_b=2, alu_op=3. Go to ADDI_WB.
  - ADDI_WB 11: reg_write, reg_dst=0, mem_to_reg=0. Go to FETCH.
- Unused codes 12–15 go to FETCH with all outputs 0.
- All outputs not listed for a state are 0.

## Timing
- Reset: while reset=1, state is forced to FETCH and every output is forced to 0, so there are no writes during reset. The first fetch begins on the first rising edge after reset goes low.
- Reset asserted mid-instruction aborts the instruction on the next rising edge; no partial register-file write follows.
- Latency in cycles, with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- ab_write is high exactly one cycle per instruction, in DECODE. A/B capture on the falling edge inside that cycle.
- illegal_op is high only in the DECODE cycle; it never coincides with any write enable other than ab_write.

## Configuration
- IMM_ARITH_EN defined: ADDI_EXEC and ADDI_WB exist, and opcode 001000 decodes to ADDI_EXEC.
- IMM_ARITH_EN undefined: those two states are not generated, codes 10–11 behave as unused, and 001000 is treated as illegal (illegal_op pulse, return to FETCH).

## Structure
- Shared package mips_ctrl_pkg holds:
  - state code localparams;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, multicycle_control_decode: a purely combinational state-to-outputs decoder. The top module keeps the state register and next-state logic.

## Test plan
- Reset held 3 cycles mid-lw, then released → all outputs 0 during reset; state=0 one cycle after release; no reg_write observed.
- lw (100011), mem_ready=1 → state sequence 0,1,2,3,4,0; reg_write && mem_to_reg only in state 4.
- sw (101011), mem_ready low for 2 cycles in MEM_WRITE → mem_write high 3 consecutive cycles, then state 0.
- FETCH with mem_ready low for 4 cycles → pc_write=0 and ir_write=0 throughout; a single pc_write+ir_write pulse on the ready cycle.
- beq then j → beq gives 0,1,8 with pc_write_cond=1 in state 8; j gives 0,1,9 with pc_source=2 and pc_write=1.
- Opcode 111111, and 001000 with IMM_ARITH_EN undefined → illegal_op one cycle in DECODE, then state 0; with the macro defined, 001000 gives 0,1,10,11 and reg_write in state 11.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU/PC select encodings and the control-word payload.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned SEL_W    = 2;

  localparam logic [STATE_W-1:0] ST_FETCH     = 4'd0;
  localparam logic [STATE_W-1:0] ST_DECODE    = 4'd1;
  localparam logic [STATE_W-1:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [STATE_W-1:0] ST_MEM_READ  = 4'd3;
  localparam logic [STATE_W-1:0] ST_MEM_WB    = 4'd4;
  localparam logic [STATE_W-1:0] ST_MEM_WRITE = 4'd5;
  localparam logic [STATE_W-1:0] ST_EXECUTE   = 4'd6;
  localparam logic [STATE_W-1:0] ST_R_WB      = 4'd7;
  localparam logic [STATE_W-1:0] ST_BRANCH    = 4'd8;
  localparam logic [STATE_W-1:0] ST_JUMP      = 4'd9;
  localparam logic [STATE_W-1:0] ST_ADDI_EXEC = 4'd10;
  localparam logic [STATE_W-1:0] ST_ADDI_WB   = 4'd11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_MEM_ADDR  = ST_MEM_ADDR,
    S_MEM_READ  = ST_MEM_READ,
    S_MEM_WB    = ST_MEM_WB,
    S_MEM_WRITE = ST_MEM_WRITE,
    S_EXECUTE   = ST_EXECUTE,
    S_R_WB      = ST_R_WB,
    S_BRANCH    = ST_BRANCH,
    S_JUMP      = ST_JUMP,
    S_ADDI_EXEC = ST_ADDI_EXEC,
    S_ADDI_WB   = ST_ADDI_WB
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [SEL_W-1:0] ALU_ADD   = 2'd0;
  localparam logic [SEL_W-1:0] ALU_SUB   = 2'd1;
  localparam logic [SEL_W-1:0] ALU_FUNCT = 2'd2;
  localparam logic [SEL_W-1:0] ALU_ADDI  = 2'd3;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             ior_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic             ab_write;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
    logic             illegal_op;
  } ctrl_t;

  // Opcodes that DECODE can dispatch; everything else is reported as illegal.
  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef IMM_ARITH_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control decoder; FETCH enables are qualified by mem_ready.
// ADDI states decode only when IMM_ARITH_EN is defined.
module multicycle_control_decode
  import mips_ctrl_pkg::*;
(
  input  state_e                state,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  output ctrl_t                 ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.ab_write   = 1'b1;
        ctrl_c.alu_src_b  = SRCB_IMM_SH;
        ctrl_c.alu_op     = ALU_ADD;
        ctrl_c.illegal_op = ~op_is_legal(opcode);
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.ior_d     = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_REG;
        ctrl_c.alu_op        = ALU_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
      end
`ifdef IMM_ARITH_EN
      S_ADDI_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADDI;
      end
      S_ADDI_WB: begin
        ctrl_c.reg_write = 1'b1;
      end
`endif
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register, next-state logic and reset gating.
// Optional macro IMM_ARITH_EN adds the addi path (ADDI_EXEC/ADDI_WB).
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 ior_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 alu_src_a,
  output logic                 ab_write,
  output logic [SEL_W-1:0]     alu_src_b,
  output logic [SEL_W-1:0]     alu_op,
  output logic [SEL_W-1:0]     pc_source,
  output logic [STATE_W-1:0]   state,
  output logic                 illegal_op
);

  state_e state_q, state_d;
  logic   is_store_q;
  ctrl_t  ctrl_c, ctrl_g;

  // Load/store direction is captured in DECODE so opcode is not needed later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_store_q <= (opcode == OP_SW);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef IMM_ARITH_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
`ifdef IMM_ARITH_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  multicycle_control_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl_c    (ctrl_c)
  );

  // Reset masks every output immediately so no write can slip out before the edge.
  assign ctrl_g = reset ? '0 : ctrl_c;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign ior_d         = ctrl_g.ior_d;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_write     = ctrl_g.reg_write;
  assign reg_dst       = ctrl_g.reg_dst;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign ab_write      = ctrl_g.ab_write;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign pc_source     = ctrl_g.pc_source;
  assign illegal_op    = ctrl_g.illegal_op;
  assign state         = reset ? '0 : STATE_W'(state_q);

endmodule
